// File: rtl/depth_engine_mc_if.sv
// Request/result handshake bundle for the multi-context escape-depth engine.
interface depth_engine_mc_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ITER_W      = 10,
  parameter int TAG_W       = 19
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_LENGTH-1:0] in_re_c;
  logic [WORD_LENGTH-1:0] in_im_c;
  logic [TAG_W-1:0]       in_tag;
  logic [ITER_W-1:0]      max_iter;
  logic                   out_valid;
  logic                   out_ready;
  logic [ITER_W-1:0]      out_depth;
  logic                   out_escaped;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output in_valid, in_re_c, in_im_c, in_tag, max_iter, out_ready,
    input  in_ready, out_valid, out_depth, out_escaped, out_tag
  );

  modport slave (
    input  in_valid, in_re_c, in_im_c, in_tag, max_iter, out_ready,
    output in_ready, out_valid, out_depth, out_escaped, out_tag
  );
endinterface

// File: rtl/depth_engine_mc.sv
// Mandelbrot escape-depth engine: NCTX pixel contexts share one 3-stage
// square/sum/update pipeline, issued round-robin; results leave tagged, possibly out of order.
module depth_engine_mc #(
  parameter int WORD_LENGTH = 32,
  parameter int FRAC        = 28,
  parameter int ITER_W      = 10,
  parameter int TAG_W       = 19,
  parameter int NCTX        = 3
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             abort,
  depth_engine_mc_if.slave bus
);
  localparam int L  = WORD_LENGTH / 2;
  localparam int HI = WORD_LENGTH - L;
  localparam int PH = 2 * HI;
  localparam int PL = 2 * L;
  localparam int PM = HI + L + 1;
  localparam int DW = 2 * WORD_LENGTH;
  localparam int CW = $clog2(NCTX);
  localparam logic signed [DW-1:0] THRESH = DW'(4) << (2 * FRAC);

  typedef enum logic [1:0] {IDLE, RUN, DONE} ctx_st_e;

  ctx_st_e st_q [NCTX];
  ctx_st_e st_d [NCTX];

  logic [NCTX-1:0][WORD_LENGTH-1:0] zr_q, zi_q, cr_q, ci_q;
  logic [NCTX-1:0][ITER_W-1:0]      k_q, mi_q;
  logic [NCTX-1:0][TAG_W-1:0]       tag_q;
  logic [NCTX-1:0]                  esc_q, busy_q;

  logic [CW-1:0] slot_q, acc_idx, drn_idx, s1_idx, s2_idx;
  logic          acc_hit, drn_hit, accept, load_out, issue, wb, wb_esc, wb_max;
  logic [2:1]    vld_pipe;

  logic signed [HI-1:0] rh, ih;
  logic [L-1:0]         rl, il;

  logic signed [PH-1:0] s1_rr_hh, s1_ii_hh, s1_ri_hh;
  logic signed [PM-1:0] s1_rr_hl, s1_ii_hl, s1_ri_hl, s1_ri_lh;
  logic [PL-1:0]        s1_rr_ll, s1_ii_ll, s1_ri_ll;
  logic signed [DW-1:0] s2_re2, s2_im2, s2_cross, mag;
  logic [WORD_LENGTH-1:0] nzr, nzi;

  logic               ov_q, oe_q;
  logic [ITER_W-1:0]  od_q;
  logic [TAG_W-1:0]   ot_q;

  // Lowest-index IDLE context takes requests; lowest-index DONE context drains first.
  always_comb begin
    acc_hit = 1'b0;
    acc_idx = '0;
    drn_hit = 1'b0;
    drn_idx = '0;
    for (int i = NCTX - 1; i >= 0; i--) begin
      if (st_q[i] == IDLE) begin
        acc_hit = 1'b1;
        acc_idx = CW'(i);
      end
      if (st_q[i] == DONE) begin
        drn_hit = 1'b1;
        drn_idx = CW'(i);
      end
    end
  end

  assign bus.in_ready = acc_hit;
  assign accept       = bus.in_valid & acc_hit & ~abort;
  assign load_out     = drn_hit & (~ov_q | bus.out_ready);
  assign issue        = (st_q[slot_q] == RUN) & ~busy_q[slot_q];
  assign wb           = vld_pipe[2];

  // S3: escape test and next z from the S2 sums.
  always_comb begin
    mag    = s2_re2 + s2_im2;
    wb_esc = mag > THRESH;
    wb_max = k_q[s2_idx] == mi_q[s2_idx];
    nzr    = WORD_LENGTH'((s2_re2 >>> FRAC) - (s2_im2 >>> FRAC)) + cr_q[s2_idx];
    nzi    = WORD_LENGTH'(s2_cross >>> FRAC) + ci_q[s2_idx];
  end

  always_comb begin
    st_d = st_q;
    for (int i = 0; i < NCTX; i++) begin
      if (accept && acc_idx == CW'(i)) st_d[i] = RUN;
      if (wb && s2_idx == CW'(i) && (wb_esc || wb_max)) st_d[i] = DONE;
      if (load_out && drn_idx == CW'(i)) st_d[i] = IDLE;
      if (abort) st_d[i] = IDLE;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCTX; i++) st_q[i] <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      zr_q   <= '0;
      zi_q   <= '0;
      cr_q   <= '0;
      ci_q   <= '0;
      k_q    <= '0;
      mi_q   <= '0;
      tag_q  <= '0;
      esc_q  <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NCTX; i++) begin
        if (abort) begin
          busy_q[i] <= 1'b0;
        end else begin
          if (accept && acc_idx == CW'(i)) begin
            zr_q[i]  <= '0;
            zi_q[i]  <= '0;
            k_q[i]   <= '0;
            esc_q[i] <= 1'b0;
            cr_q[i]  <= bus.in_re_c;
            ci_q[i]  <= bus.in_im_c;
            mi_q[i]  <= bus.max_iter;
            tag_q[i] <= bus.in_tag;
          end
          if (issue && slot_q == CW'(i)) busy_q[i] <= 1'b1;
          // On max_iter the count is left at k == max_iter, which is the reported depth.
          if (wb && s2_idx == CW'(i)) begin
            busy_q[i] <= 1'b0;
            if (wb_esc) begin
              esc_q[i] <= 1'b1;
            end else if (!wb_max) begin
              zr_q[i] <= nzr;
              zi_q[i] <= nzi;
              k_q[i]  <= k_q[i] + ITER_W'(1);
            end
          end
        end
      end
    end
  end

  always_comb begin
    rh = zr_q[slot_q][WORD_LENGTH-1:L];
    rl = zr_q[slot_q][L-1:0];
    ih = zi_q[slot_q][WORD_LENGTH-1:L];
    il = zi_q[slot_q][L-1:0];
  end

  // S1 splits each operand into a signed high and unsigned low half; S2 recombines.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q   <= '0;
      vld_pipe <= '0;
      s1_idx   <= '0;
      s2_idx   <= '0;
      s1_rr_hh <= '0;
      s1_ii_hh <= '0;
      s1_ri_hh <= '0;
      s1_rr_hl <= '0;
      s1_ii_hl <= '0;
      s1_ri_hl <= '0;
      s1_ri_lh <= '0;
      s1_rr_ll <= '0;
      s1_ii_ll <= '0;
      s1_ri_ll <= '0;
      s2_re2   <= '0;
      s2_im2   <= '0;
      s2_cross <= '0;
    end else begin
      if (abort) slot_q <= '0;
      else       slot_q <= (slot_q == CW'(NCTX - 1)) ? '0 : slot_q + CW'(1);
      vld_pipe[1] <= issue & ~abort;
      vld_pipe[2] <= vld_pipe[1] & ~abort;
      s1_idx   <= slot_q;
      s1_rr_hh <= PH'(rh) * PH'(rh);
      s1_ii_hh <= PH'(ih) * PH'(ih);
      s1_ri_hh <= PH'(rh) * PH'(ih);
      s1_rr_hl <= PM'(rh) * PM'($signed({1'b0, rl}));
      s1_ii_hl <= PM'(ih) * PM'($signed({1'b0, il}));
      s1_ri_hl <= PM'(rh) * PM'($signed({1'b0, il}));
      s1_ri_lh <= PM'(ih) * PM'($signed({1'b0, rl}));
      s1_rr_ll <= PL'(rl) * PL'(rl);
      s1_ii_ll <= PL'(il) * PL'(il);
      s1_ri_ll <= PL'(rl) * PL'(il);
      s2_idx   <= s1_idx;
      s2_re2   <= (DW'(s1_rr_hh) <<< (2 * L)) + (DW'(s1_rr_hl) <<< (L + 1))
                  + DW'($signed({1'b0, s1_rr_ll}));
      s2_im2   <= (DW'(s1_ii_hh) <<< (2 * L)) + (DW'(s1_ii_hl) <<< (L + 1))
                  + DW'($signed({1'b0, s1_ii_ll}));
      s2_cross <= ((DW'(s1_ri_hh) <<< (2 * L)) + ((DW'(s1_ri_hl) + DW'(s1_ri_lh)) <<< L)
                  + DW'($signed({1'b0, s1_ri_ll}))) <<< 1;
    end
  end

  // Output register reloads in the same cycle it is consumed, so results stream without bubbles.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      ov_q <= 1'b0;
      oe_q <= 1'b0;
      od_q <= '0;
      ot_q <= '0;
    end else if (abort) begin
      ov_q <= 1'b0;
      oe_q <= 1'b0;
      od_q <= '0;
      ot_q <= '0;
    end else if (load_out) begin
      ov_q <= 1'b1;
      oe_q <= esc_q[drn_idx];
      od_q <= k_q[drn_idx];
      ot_q <= tag_q[drn_idx];
    end else if (bus.out_ready) begin
      ov_q <= 1'b0;
    end
  end

  assign bus.out_valid   = ov_q;
  assign bus.out_escaped = oe_q;
  assign bus.out_depth   = od_q;
  assign bus.out_tag     = ot_q;
endmodule
